// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: widths,
// operation codes, FSM states and the small sign-handling helpers.
package muldiv_ctrl_pkg;

    localparam int W_FUNC    = 5;
    localparam int W_DATA    = 32;
    localparam int DIV_ITERS = 32;

    localparam logic [W_FUNC-1:0] FUNC_NONE = 5'b00000;
    localparam logic [W_FUNC-1:0] FUNC_MUL  = 5'b00001;
    localparam logic [W_FUNC-1:0] FUNC_DIV  = 5'b00010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic [W_DATA-1:0] abs_val(input logic [W_DATA-1:0] v,
                                                  input logic               is_signed);
        return (is_signed && v[W_DATA-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W_DATA-1:0] negate_if(input logic [W_DATA-1:0] v,
                                                    input logic               neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic [W_FUNC-1:0] mulalu_func;
    logic              mulalu_sign;
    logic [W_DATA-1:0] source_a;
    logic [W_DATA-1:0] source_b;
    logic              hi_write;
    logic              lo_write;
    logic [W_DATA-1:0] wdata;
    logic              flush;
    logic [W_DATA-1:0] hi;
    logic [W_DATA-1:0] lo;
    logic              stall;

    modport master (
        output mulalu_func, mulalu_sign, source_a, source_b,
        output hi_write, lo_write, wdata, flush,
        input  hi, lo, stall
    );

    modport slave (
        input  mulalu_func, mulalu_sign, source_a, source_b,
        input  hi_write, lo_write, wdata, flush,
        output hi, lo, stall
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring radix-2 division iteration on a packed {remainder, quotient}
// register: shift left, trial-subtract the divisor, keep or restore.
module div_step
    import muldiv_ctrl_pkg::*;
(
    input  logic [2*W_DATA-1:0] rq,
    input  logic [W_DATA-1:0]   divisor,
    output logic [2*W_DATA-1:0] rq_next
);

    logic [W_DATA:0] partial;
    logic [W_DATA:0] diff;

    // Remainder stays below the divisor, so the 33-bit borrow is an exact compare.
    assign partial = rq[2*W_DATA-1:W_DATA-1];
    assign diff    = partial - {1'b0, divisor};

    always_comb begin
        rq_next = {partial[W_DATA-1:0], rq[W_DATA-2:0], 1'b0};
        if (!diff[W_DATA]) begin
            rq_next = {diff[W_DATA-1:0], rq[W_DATA-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers;
// holds the pipeline via stall while an operation is in flight.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_ctrl_if.slave bus
);

    state_t              state, state_next;
    logic [4:0]          cnt;
    logic                req_valid, accept, stall_c;
    logic                mul_last, div_last;
    logic [W_DATA-1:0]   op_a, op_b;
    logic                neg_q, neg_r, div_zero;
    logic [2*W_DATA-1:0] rq, rq_next;
    logic [2*W_DATA-1:0] prod_mag, prod;
    logic [W_DATA-1:0]   quo_fix, rem_fix;

    assign req_valid = (bus.mulalu_func != FUNC_NONE);
    assign accept    = (state == IDLE) && req_valid && !bus.flush;
    assign mul_last  = (state == MUL) && (cnt == 5'(MUL_CYCLES - 1));
    assign div_last  = (cnt == 5'(DIV_ITERS - 1));
    assign bus.stall = stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_c = 1'b1;
                    if (bus.mulalu_func == FUNC_MUL) begin
                        state_next = MUL;
                    end else if (bus.source_b == '0) begin
                        state_next = FIX;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL: begin
                stall_c = 1'b1;
                if (mul_last) state_next = IDLE;
            end
            DIV: begin
                stall_c = 1'b1;
                if (div_last) state_next = FIX;
            end
            FIX: begin
                stall_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + 5'd1;
        end
    end

    // Operand capture: magnitudes plus sign flags, so the sources are free afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a     <= abs_val(bus.source_a, bus.mulalu_sign);
            op_b     <= abs_val(bus.source_b, bus.mulalu_sign);
            neg_q    <= bus.mulalu_sign & (bus.source_a[W_DATA-1] ^ bus.source_b[W_DATA-1]);
            neg_r    <= bus.mulalu_sign & bus.source_a[W_DATA-1];
            div_zero <= (bus.source_b == '0);
            rq       <= {{W_DATA{1'b0}}, abs_val(bus.source_a, bus.mulalu_sign)};
        end else if (state == DIV) begin
            rq <= rq_next;
        end
    end

    div_step u_div_step (
        .rq      (rq),
        .divisor (op_b),
        .rq_next (rq_next)
    );

    assign prod_mag = {{W_DATA{1'b0}}, op_a} * {{W_DATA{1'b0}}, op_b};
    assign prod     = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix  = negate_if(rq[W_DATA-1:0], neg_q);
    assign rem_fix  = negate_if(rq[2*W_DATA-1:W_DATA], neg_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hi <= '0;
            bus.lo <= '0;
        end else if (!bus.flush) begin
            if (state == IDLE) begin
                if (bus.hi_write) bus.hi <= bus.wdata;
                if (bus.lo_write) bus.lo <= bus.wdata;
            end else if (mul_last) begin
                bus.hi <= prod[2*W_DATA-1:W_DATA];
                bus.lo <= prod[W_DATA-1:0];
            end else if (state == FIX && !div_zero) begin
                bus.hi <= rem_fix;
                bus.lo <= quo_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, stall lengths,
// HI/LO writes, flush and asynchronous reset behaviour.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.mulalu_func = FUNC_NONE;
        bus.mulalu_sign = 1'b0;
        bus.hi_write    = 1'b0;
        bus.lo_write    = 1'b0;
        bus.wdata       = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic wait_idle(inout int cyc);
        while (bus.stall && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.mulalu_func = FUNC_NONE;
            bus.source_a    = $urandom;
            bus.source_b    = $urandom;
        end
    endtask

    task automatic run_op(input logic [4:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        bus.mulalu_func = f;
        bus.mulalu_sign = s;
        bus.source_a    = a;
        bus.source_b    = b;
        #1;
        cyc = 0;
        wait_idle(cyc);
    endtask

    initial begin
        clear_inputs();
        bus.source_a = '0;
        bus.source_b = '0;
        #3;
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_stall", bus.stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("umul_cycles", n, 2);
        check("umul_hi", bus.hi, 64'hFFFF_FFFE);
        check("umul_lo", bus.lo, 64'h0000_0001);

        run_op(FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, n);
        check("smul_hi", bus.hi, 64'hFFFF_FFFF);
        check("smul_lo", bus.lo, 64'hFFFF_FFF1);

        run_op(FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, n);
        check("sdiv_cycles", n, 34);
        check("sdiv_lo", bus.lo, 64'hFFFF_FFFD);
        check("sdiv_hi", bus.hi, 64'hFFFF_FFFF);

        run_op(FUNC_DIV, 1'b0, 32'd100, 32'd7, n);
        check("udiv_lo", bus.lo, 14);
        check("udiv_hi", bus.hi, 2);

        run_op(FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("ovf_lo", bus.lo, 64'h8000_0000);
        check("ovf_hi", bus.hi, 0);

        run_op(FUNC_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, n);
        check("sdiv2_lo", bus.lo, 64'hFFFF_FFFD);
        check("sdiv2_hi", bus.hi, 1);

        // MTHI/MTLO preload, then divide by zero must leave them alone
        @(negedge clk);
        bus.hi_write = 1'b1; bus.wdata = 32'h11;
        @(negedge clk);
        bus.hi_write = 1'b0; bus.lo_write = 1'b1; bus.wdata = 32'h22;
        @(negedge clk);
        bus.lo_write = 1'b0;
        check("mthi", bus.hi, 32'h11);
        check("mtlo", bus.lo, 32'h22);
        run_op(FUNC_DIV, 1'b0, 32'd5, 32'd0, n);
        check("div0_cycles", n, 2);
        check("div0_hi", bus.hi, 32'h11);
        check("div0_lo", bus.lo, 32'h22);

        // Flush at iteration 10 of a divide
        @(negedge clk);
        bus.mulalu_func = FUNC_DIV; bus.source_a = 32'd100; bus.source_b = 32'd7;
        @(posedge clk);
        #1 bus.mulalu_func = FUNC_NONE;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_pre_stall", bus.stall, 1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        #1;
        check("flush_stall", bus.stall, 0);
        check("flush_hi", bus.hi, 32'h11);
        check("flush_lo", bus.lo, 32'h22);
        run_op(FUNC_MUL, 1'b0, 32'd6, 32'd7, n);
        check("postflush_cycles", n, 2);
        check("postflush_lo", bus.lo, 42);
        check("postflush_hi", bus.hi, 0);

        // lo_write ignored during DIV, honoured in IDLE
        @(negedge clk);
        bus.mulalu_func = FUNC_DIV; bus.source_a = 32'd100; bus.source_b = 32'd7;
        @(posedge clk);
        #1 bus.mulalu_func = FUNC_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.lo_write = 1'b1; bus.wdata = 32'h5A;
        @(posedge clk);
        #1 bus.lo_write = 1'b0;
        check("busy_write_lo", bus.lo, 42);
        n = 0;
        wait_idle(n);
        check("busy_div_done", bus.stall, 0);
        check("busy_div_lo", bus.lo, 14);
        @(negedge clk);
        bus.lo_write = 1'b1; bus.wdata = 32'h5A;
        @(posedge clk);
        #1 bus.lo_write = 1'b0;
        check("idle_write_lo", bus.lo, 32'h5A);

        // Write and request in the same IDLE cycle
        @(negedge clk);
        bus.mulalu_func = FUNC_MUL; bus.source_a = 32'd2; bus.source_b = 32'd3;
        bus.lo_write = 1'b1; bus.wdata = 32'h99;
        @(posedge clk);
        #1 bus.mulalu_func = FUNC_NONE; bus.lo_write = 1'b0;
        check("same_cycle_write", bus.lo, 32'h99);
        @(posedge clk);
        #1;
        check("same_cycle_result", bus.lo, 6);
        check("same_cycle_stall", bus.stall, 0);

        // Flush in the final MUL cycle suppresses the write
        @(negedge clk);
        bus.mulalu_func = FUNC_MUL; bus.source_a = 32'd9; bus.source_b = 32'd9;
        @(posedge clk);
        #1 bus.mulalu_func = FUNC_NONE; bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("mulflush_lo", bus.lo, 6);
        check("mulflush_stall", bus.stall, 0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.mulalu_func = FUNC_DIV; bus.source_a = 32'd1000; bus.source_b = 32'd3;
        @(posedge clk);
        #1 bus.mulalu_func = FUNC_NONE;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("prerst_stall", bus.stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(FUNC_MUL, 1'b0, 32'd3, 32'd4, n);
        check("postrst_cycles", n, 2);
        check("postrst_lo", bus.lo, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 1, meaning the number of MUL-state compute cycles (range 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port mulalu_func, input, W_FUNC, operation request: FUNC_MUL or FUNC_DIV; 5'b00000 means no request.
REQ-005 SHALL have port mulalu_sign, input, 1, signed operation (1) or unsigned (0).
REQ-006 SHALL have port source_a, input, W_DATA, multiplicand or dividend.
REQ-007 SHALL have port source_b, input, W_DATA, multiplier or divisor.
REQ-008 SHALL have port hi_write and lo_write, inputs, 1 each, MTHI/MTLO write strobes.
REQ-009 SHALL have port wdata, input, W_DATA, MTHI/MTLO write data.
REQ-010 SHALL have port flush, input, 1, aborts any in-flight operation.
REQ-011 SHALL have port hi and lo, outputs, W_DATA each, architectural HI/LO registers.
REQ-012 SHALL have port stall, output, 1, pipeline hold request.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-014 In IDLE with a valid request (mulalu_func nonzero) and flush=0, SHALL capture the operands, absolute values when signed, and the result-sign flags, then go to MUL or DIV.
REQ-015 stall SHALL be combinational: 1 when (IDLE and valid request and flush=0) or state is MUL, DIV or FIX; otherwise 0.
REQ-016 MUL SHALL last MUL_CYCLES cycles; at the edge ending the last cycle, {hi,lo} SHALL receive the 64-bit product, signed or unsigned per the captured sign, and the FSM SHALL return to IDLE.
REQ-017 DIV SHALL perform exactly 32 restoring radix-2 iterations (one per cycle, 5-bit counter 0..31), then go to FIX.
REQ-018 FIX SHALL apply the signs in one cycle: quotient negated if the operand signs differ, remainder carrying the dividend's sign; at its ending edge lo=quotient, hi=remainder, and the FSM SHALL return to IDLE.
REQ-019 Latencies SHALL be: MUL stall high for 1+MUL_CYCLES cycles; DIV stall high for 34 cycles.
REQ-020 Divide by zero SHALL go IDLE->FIX->IDLE (stall 2 cycles) and leave hi and lo unchanged.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no trap).
REQ-022 hi_write/lo_write SHALL update hi/lo from wdata only in IDLE; they are ignored in other states.
REQ-023 A write and a request in the same IDLE cycle SHALL both be accepted; the operation result later overwrites the written value.
REQ-024 Requests in non-IDLE states SHALL be ignored; operands SHALL be held internally, so source_a and source_b may change after capture.
REQ-025 flush in any state SHALL force IDLE at the next edge, with hi/lo unchanged and no request captured; flush in the final MUL or FIX cycle SHALL suppress the write.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0 and stall=0 (no request present), including in the middle of an operation.
REQ-027 After reset release, the first valid request SHALL be accepted on the first rising edge.

Structure
REQ-028 The FSM state enum, the iteration-count constant (32) and the FUNC_MUL/FUNC_DIV and W_FUNC/W_DATA definitions SHALL reside in the shared includes package.
REQ-029 A single sub-module div_step SHALL implement one combinational restoring iteration ({rem,quo} in, divisor in, {rem,quo} out); multiply SHALL be inferred inline.

Verification
REQ-030 Unsigned MUL 0xFFFFFFFF*0xFFFFFFFF, MUL_CYCLES=1 -> stall high 2 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 Signed DIV -7/2 -> stall high 34 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned DIV 100/7 -> lo=14, hi=2.
REQ-032 DIV x/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> stall 2 cycles, hi=0x11, lo=0x22 unchanged.
REQ-033 Start DIV, assert flush at iteration 10 -> IDLE next cycle, stall 0, hi/lo unchanged; a new MUL is accepted on the following edge.
REQ-034 Deassert rst_n mid-DIV -> stall 0, hi=lo=0 immediately (before the next clock edge).
REQ-035 lo_write with wdata=0x5A during DIV -> ignored; the same request in IDLE -> lo=0x5A after one edge.
